// File: rtl/string_reader.sv
`default_nettype none
// ============================================================================
//  Module   : string_reader
//  Purpose  : Walks a small synchronous string ROM from a start address and
//             streams each byte over a valid/ready interface until the 0x00
//             terminator, with a byte-count guard against runaway strings.
//  Revision : 1.0  initial release
// ============================================================================
module string_reader #(
  parameter int unsigned AW     = 4,
  parameter int unsigned DW     = 8,
  parameter int unsigned MAXLEN = 16
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  input  logic [AW-1:0] start_addr_i,
  output logic [AW-1:0] mem_addr_o,
  input  logic [DW-1:0] mem_data_i,
  output logic [DW-1:0] tx_data_o,
  output logic          tx_valid_o,
  input  logic          tx_ready_i,
  output logic          busy_o,
  output logic          done_o,
  output logic [AW:0]   len_o,
  output logic          err_o
);

  localparam logic [AW:0] c_maxlen = (AW+1)'(MAXLEN);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_CHECK = 3'd2,
    S_SEND  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t        r_state;
  logic [AW-1:0] r_ptr;
  logic [AW:0]   r_count;
  logic [AW:0]   w_count_inc;
  logic          w_handshake;

  // The memory registers the address at the end of FETCH, so the pointer
  // drives it directly in every state; reads outside FETCH are simply unused.
  assign mem_addr_o  = r_ptr;
  assign busy_o      = (r_state != S_IDLE);
  assign w_count_inc = r_count + 1'b1;
  assign w_handshake = tx_valid_o && tx_ready_i;

  // Sequencer: fetch / check / send loop. done_o, len_o and err_o are loaded
  // on the transition into DONE so they are all valid in the DONE cycle.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_count    <= '0;
      tx_data_o  <= '0;
      tx_valid_o <= 1'b0;
      done_o     <= 1'b0;
      len_o      <= '0;
      err_o      <= 1'b0;
    end else begin
      done_o <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_ptr   <= start_addr_i;
            r_count <= '0;
            r_state <= S_FETCH;
          end
        end
        S_FETCH: begin
          r_state <= S_CHECK;
        end
        S_CHECK: begin
          if (mem_data_i == '0) begin
            // Terminator: never emitted, string ends cleanly.
            r_state <= S_DONE;
            done_o  <= 1'b1;
            len_o   <= r_count;
            err_o   <= 1'b0;
          end else begin
            tx_data_o  <= mem_data_i;
            tx_valid_o <= 1'b1;
            r_state    <= S_SEND;
          end
        end
        S_SEND: begin
          // Byte stays on the stream until the consumer takes it.
          if (w_handshake) begin
            tx_valid_o <= 1'b0;
            r_ptr      <= r_ptr + 1'b1;
            r_count    <= w_count_inc;
            if (w_count_inc == c_maxlen) begin
              // Guard reached without a terminator.
              r_state <= S_DONE;
              done_o  <= 1'b1;
              len_o   <= w_count_inc;
              err_o   <= 1'b1;
            end else begin
              r_state <= S_FETCH;
            end
          end
        end
        S_DONE: begin
          // Any start_i seen here is deliberately dropped.
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_string_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_string_reader
//  Purpose  : Self-checking bench for string_reader: directed vector table,
//             reset-in-flight sequence and randomized ROM/backpressure runs
//             against a queue-based reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_string_reader;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       start_i;
  logic [3:0] start_addr_i;
  logic [3:0] mem_addr_o;
  logic [7:0] mem_data_i;
  logic [7:0] tx_data_o;
  logic       tx_valid_o;
  logic       tx_ready_i;
  logic       busy_o;
  logic       done_o;
  logic [4:0] len_o;
  logic       err_o;

  string_reader #(.AW(4), .DW(8), .MAXLEN(16)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .start_i      (start_i),
    .start_addr_i (start_addr_i),
    .mem_addr_o   (mem_addr_o),
    .mem_data_i   (mem_data_i),
    .tx_data_o    (tx_data_o),
    .tx_valid_o   (tx_valid_o),
    .tx_ready_i   (tx_ready_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .len_o        (len_o),
    .err_o        (err_o)
  );

  always #5 clk_i = ~clk_i;

  // Synchronous ROM model, one cycle read latency.
  logic [7:0] rom [16];
  always_ff @(posedge clk_i) mem_data_i <= rom[mem_addr_o];

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int         first_t;
  int         done_t;
  int         got_len;
  int         got_err;

  typedef struct {
    logic [3:0] addr;
    bit         noterm;
    bit         rnd;
    int         len;
    int         err;
    logic [7:0] first_b;
    logic [7:0] last_b;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load_default();
    logic [7:0] img [16] = '{8'h41, 8'h42, 8'h43, 8'h00, 8'h45, 8'h46, 8'h47, 8'h48,
                             8'h49, 8'h50, 8'h51, 8'h52, 8'h53, 8'h54, 8'h55, 8'h00};
    for (int i = 0; i < 16; i++) rom[i] = img[i];
  endtask

  task automatic load_noterm();
    for (int i = 0; i < 16; i++) rom[i] = 8'(8'h60 + i);
  endtask

  // Reference: read bytes from the start address (wrapping) until a zero
  // or until 16 bytes have been produced.
  task automatic model(input logic [3:0] a, output int len, output int err);
    int p;
    exp_q.delete();
    err = 1;
    p = int'(a);
    for (int i = 0; i < 16; i++) begin
      if (rom[p] == 8'h00) begin
        err = 0;
        break;
      end
      exp_q.push_back(rom[p]);
      p = (p + 1) % 16;
    end
    len = exp_q.size();
  endtask

  // One complete string transaction; records the accepted bytes and timing.
  task automatic run_string(input logic [3:0] a, input bit rnd);
    int stall;
    bit prev_hold;
    logic [7:0] prev_data;
    got_q.delete();
    first_t = -1; done_t = -1; stall = 0; prev_hold = 0; prev_data = '0;
    @(posedge clk_i); #1;
    start_i = 1'b1; start_addr_i = a; tx_ready_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0; start_addr_i = 4'($urandom);
    check("addr_at_fetch", mem_addr_o, a);
    check("busy_after_start", busy_o, 1);
    for (int t = 1; t < 2000; t++) begin
      if (t > 1) begin @(posedge clk_i); #1; end
      if (prev_hold) begin
        check("hold_valid", tx_valid_o, 1);
        check("hold_data", tx_data_o, prev_data);
      end
      if (!rnd) tx_ready_i = 1'b1;
      else if (stall > 0) begin tx_ready_i = 1'b0; stall--; end
      else if ($urandom_range(7) == 0) begin tx_ready_i = 1'b0; stall = 19; end
      else tx_ready_i = 1'($urandom_range(1));
      if (tx_valid_o && first_t < 0) first_t = t;
      if (tx_valid_o && tx_ready_i) got_q.push_back(tx_data_o);
      prev_hold = tx_valid_o && !tx_ready_i;
      prev_data = tx_data_o;
      start_i = (rnd && busy_o) ? 1'($urandom_range(1)) : 1'b0;
      start_addr_i = 4'($urandom);
      if (done_o) begin
        done_t = t; got_len = int'(len_o); got_err = int'(err_o);
        break;
      end
    end
    check("run_timeout", int'(done_t >= 0), 1);
    @(posedge clk_i); #1;
    start_i = 1'b0;
    check("idle_after_done", busy_o, 0);
    check("done_one_cycle", done_o, 0);
  endtask

  task automatic compare_run(input int len, input int err, input bit rnd);
    check("len", got_len, len);
    check("err", got_err, err);
    check("stream_size", got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check("stream_byte", got_q[i], exp_q[i]);
    if (len > 0) check("first_valid_latency", first_t, 3);
    else         check("no_valid_on_empty", first_t, -1);
    if (!rnd) check("done_latency", done_t, (err != 0) ? 3*len + 1 : 3*len + 3);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int mlen, merr;
    vecs[0] = '{addr: 4'd0,  noterm: 0, rnd: 0, len: 3,  err: 0, first_b: 8'h41, last_b: 8'h43};
    vecs[1] = '{addr: 4'd4,  noterm: 0, rnd: 0, len: 11, err: 0, first_b: 8'h45, last_b: 8'h55};
    vecs[2] = '{addr: 4'd3,  noterm: 0, rnd: 0, len: 0,  err: 0, first_b: 8'h00, last_b: 8'h00};
    vecs[3] = '{addr: 4'd13, noterm: 0, rnd: 0, len: 2,  err: 0, first_b: 8'h54, last_b: 8'h55};
    vecs[4] = '{addr: 4'd0,  noterm: 0, rnd: 1, len: 3,  err: 0, first_b: 8'h41, last_b: 8'h43};
    vecs[5] = '{addr: 4'd14, noterm: 1, rnd: 0, len: 16, err: 1, first_b: 8'h6E, last_b: 8'h6D};

    rst_ni = 1'b0; start_i = 1'b0; start_addr_i = '0; tx_ready_i = 1'b0;
    load_default();
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_busy", busy_o, 0);
    check("rst_valid", tx_valid_o, 0);
    check("rst_done", done_o, 0);
    check("rst_len", len_o, 0);
    check("rst_err", err_o, 0);
    check("rst_addr", mem_addr_o, 0);
    rst_ni = 1'b1;

    // Directed vector table.
    for (int v = 0; v < 6; v++) begin
      if (vecs[v].noterm) load_noterm(); else load_default();
      model(vecs[v].addr, mlen, merr);
      run_string(vecs[v].addr, vecs[v].rnd);
      compare_run(vecs[v].len, vecs[v].err, vecs[v].rnd);
      if (vecs[v].len > 0 && got_q.size() > 0) begin
        check("vec_first_byte", got_q[0], vecs[v].first_b);
        check("vec_last_byte", got_q[got_q.size()-1], vecs[v].last_b);
      end
    end

    // Reset while a byte is pending in SEND (len_o=16, err_o=1 from above).
    begin
      bit seen;
      seen = 0;
      @(posedge clk_i); #1;
      start_i = 1'b1; start_addr_i = 4'd5; tx_ready_i = 1'b0;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      for (int t = 0; t < 10 && !seen; t++) begin
        if (tx_valid_o) seen = 1;
        else begin @(posedge clk_i); #1; end
      end
      check("reach_send", int'(seen), 1);
      rst_ni = 1'b0;
      @(posedge clk_i); #1;
      rst_ni = 1'b1;
      check("midrst_valid", tx_valid_o, 0);
      check("midrst_data", tx_data_o, 0);
      check("midrst_busy", busy_o, 0);
      check("midrst_done", done_o, 0);
      check("midrst_len", len_o, 0);
      check("midrst_err", err_o, 0);
      check("midrst_addr", mem_addr_o, 0);
      @(posedge clk_i); #1;
      check("midrst_stays_idle", busy_o, 0);
      load_default();
      model(4'd0, mlen, merr);
      run_string(4'd0, 1'b0);
      compare_run(3, 0, 1'b0);
    end

    // Randomized ROM images, start addresses and backpressure.
    for (int r = 0; r < 24; r++) begin
      logic [3:0] a;
      bit rnd;
      for (int i = 0; i < 16; i++) begin
        if (r % 6 != 5 && $urandom_range(3) == 0) rom[i] = 8'h00;
        else rom[i] = 8'($urandom_range(255, 1));
      end
      a   = 4'($urandom);
      rnd = 1'($urandom_range(1));
      model(a, mlen, merr);
      run_string(a, rnd);
      compare_run(mlen, merr, rnd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
